spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_tick_gen.sv | 33 +++
 rtl/spi_master.sv | 131 +++++++++++++
 tb/tb_spi_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame/timing constants,
// common to the SPI master and slave.
package spi_pkg;

  localparam int unsigned SpiWidth  = 32;
  localparam int unsigned SpiClkDiv = 4;
  localparam int unsigned SpiCsGap  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StGap
  } spi_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer for the SPI master.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   clr    - hold counter at zero (used while the FSM is outside a timed phase)
//   tick   - one-cycle pulse on the last clk of each CLK_DIV-cycle phase
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = spi_pkg::SpiClkDiv
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt;

  // Every phase change happens on a tick, so wrapping on tick restarts the
  // count exactly at phase entry.
  always_ff @(posedge clk) begin
    if (!rst_n || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CntLast) && !clr;

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (SCK idle low, sample on rising edge, MSB first).
// Ports:
//   clk, rst_n         - clock and synchronous active-low reset
//   start, tx_data     - frame request and word to send (sampled in idle only)
//   busy, done         - frame in progress / one-cycle end-of-frame pulse
//   rx_data            - received word, updated on the done cycle
//   sck, ssel, mosi    - SPI outputs (ssel active low)
//   miso               - SPI serial input
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH   = SpiWidth,
  parameter int unsigned CLK_DIV = SpiClkDiv,
  parameter int unsigned CS_GAP  = SpiCsGap
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sck,
  output logic             ssel,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam int unsigned GapW = $clog2(CS_GAP + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

  spi_state_e       state;
  // {mosi, tx_shift} together form the full transmit shift register; mosi
  // is its registered MSB, so only the remaining bits are stored here.
  logic [WIDTH-2:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [BitW-1:0]  bitcnt;
  logic [GapW-1:0]  gap_cnt;
  logic             tick;
  logic             tick_clr;

  assign tick_clr = (state == StIdle) || (state == StGap);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      tx_shift <= '0;
      rx_shift <= '0;
      bitcnt   <= '0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      sck      <= 1'b0;
      ssel     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            mosi     <= tx_data[WIDTH-1];
            tx_shift <= tx_data[WIDTH-2:0];
            bitcnt   <= '0;
            ssel     <= 1'b0;
            busy     <= 1'b1;
            state    <= StSetup;
          end
        end
        StSetup: begin
          if (tick) begin
            sck   <= 1'b1;
            state <= StHigh;
          end
        end
        StHigh: begin
          if (tick) begin
            sck      <= 1'b0;
            rx_shift <= {rx_shift[WIDTH-2:0], miso};
            bitcnt   <= bitcnt + 1'b1;
            if (bitcnt == BitLast) begin
              // Last bit: park mosi low on this falling edge so it is 0 in GAP.
              mosi  <= 1'b0;
              state <= StHold;
            end else begin
              mosi     <= tx_shift[WIDTH-2];
              tx_shift <= {tx_shift[WIDTH-3:0], 1'b0};
              state    <= StLow;
            end
          end
        end
        StLow: begin
          if (tick) begin
            sck   <= 1'b1;
            state <= StHigh;
          end
        end
        StHold: begin
          if (tick) begin
            ssel    <= 1'b1;
            done    <= 1'b1;
            rx_data <= rx_shift;
            gap_cnt <= '0;
            state   <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt == GapLast) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: loopback and mode-0 slave model on a
// 32-bit/CLK_DIV=4 instance, loopback on an 8-bit/CLK_DIV=2 instance.
module tb_spi_master;

  localparam int unsigned WA = 32;
  localparam int unsigned DA = 4;
  localparam int unsigned GA = 2;
  localparam int unsigned WB = 8;
  localparam int unsigned DB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic          start_a = 1'b0;
  logic [WA-1:0] tx_a = '0;
  logic          busy_a, done_a, sck_a, ssel_a, mosi_a, miso_a;
  logic [WA-1:0] rx_a;

  logic          start_b = 1'b0;
  logic [WB-1:0] tx_b = '0;
  logic          busy_b, done_b, sck_b, ssel_b, mosi_b;
  logic [WB-1:0] rx_b;

  int errors = 0;
  int checks = 0;

  // Slave model state
  bit            use_slave = 1'b0;
  logic [31:0]   slave_resp = '0;
  logic [31:0]   slave_out = '0;
  logic [31:0]   slave_rx = '0;

  assign miso_a = use_slave ? slave_out[31] : mosi_a;

  spi_master #(.WIDTH(WA), .CLK_DIV(DA), .CS_GAP(GA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .busy(busy_a),
    .done(done_a), .rx_data(rx_a), .sck(sck_a), .ssel(ssel_a), .mosi(mosi_a),
    .miso(miso_a)
  );

  spi_master #(.WIDTH(WB), .CLK_DIV(DB), .CS_GAP(GA)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .busy(busy_b),
    .done(done_b), .rx_data(rx_b), .sck(sck_b), .ssel(ssel_b), .mosi(mosi_b),
    .miso(mosi_b)
  );

  // Mode-0 slave: shifts response out MSB first, next bit after each falling
  // SCK; captures mosi on each rising SCK.
  always begin
    @(negedge ssel_a);
    slave_out = slave_resp;
    while (!ssel_a) begin
      @(posedge sck_a or posedge ssel_a);
      if (!ssel_a) begin
        slave_rx = {slave_rx[30:0], mosi_a};
        @(negedge sck_a or posedge ssel_a);
        if (!ssel_a) slave_out = slave_out << 1;
      end
    end
  end

  // Free-running monitors; the stimulus block works on differences.
  int   ssel_low_a = 0, sck_rise_a = 0, done_cnt_a = 0, mosi_bad_a = 0, sck_bad_a = 0;
  int   ssel_low_b = 0, sck_rise_b = 0, done_cnt_b = 0, sck_bad_b = 0;
  logic sck_prev_a = 1'b0, ssel_prev_a = 1'b1, mosi_prev_a = 1'b0, sck_prev_b = 1'b0;

  always @(negedge clk) begin
    if (!ssel_a) ssel_low_a++;
    if (sck_a && !sck_prev_a) sck_rise_a++;
    if (done_a) done_cnt_a++;
    if (sck_a && ssel_a) sck_bad_a++;
    if (rst_n && (mosi_a !== mosi_prev_a) && !(sck_prev_a && !sck_a)
        && !(ssel_prev_a && !ssel_a)) mosi_bad_a++;
    sck_prev_a  = sck_a;
    ssel_prev_a = ssel_a;
    mosi_prev_a = mosi_a;
    if (!ssel_b) ssel_low_b++;
    if (sck_b && !sck_prev_b) sck_rise_b++;
    if (done_b) done_cnt_b++;
    if (sck_b && ssel_b) sck_bad_b++;
    sck_prev_b = sck_b;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One frame on instance A; expected rx is the tx word in loopback or the
  // slave response otherwise.
  task automatic frame_a(input string tag, input logic [31:0] tx, input bit slave,
                         input logic [31:0] resp);
    int  s_low, s_rise, s_done;
    bit  got;
    use_slave  = slave;
    slave_resp = resp;
    s_low  = ssel_low_a;
    s_rise = sck_rise_a;
    s_done = done_cnt_a;
    tx_a    = tx;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check({tag, " busy"}, 32'(busy_a), 32'd1);
    got = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      step();
      if (done_a) got = 1'b1;
    end
    check({tag, " done"}, 32'(got), 32'd1);
    check({tag, " rx"}, rx_a, slave ? resp : tx);
    if (slave) check({tag, " slave_rx"}, slave_rx, tx);
    check({tag, " ssel_low"}, 32'(ssel_low_a - s_low), DA * (2 * WA + 1));
    check({tag, " sck_rises"}, 32'(sck_rise_a - s_rise), WA);
    for (int n = 0; n < 20 && busy_a; n++) step();
    check({tag, " idle"}, 32'(busy_a), 32'd0);
    check({tag, " done_count"}, 32'(done_cnt_a - s_done), 32'd1);
  endtask

  task automatic frame_b(input string tag, input logic [7:0] tx);
    int s_low, s_rise;
    bit got;
    s_low  = ssel_low_b;
    s_rise = sck_rise_b;
    tx_b    = tx;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 500 && !got; n++) begin
      step();
      if (done_b) got = 1'b1;
    end
    check({tag, " done"}, 32'(got), 32'd1);
    check({tag, " rx"}, 32'(rx_b), 32'(tx));
    check({tag, " ssel_low"}, 32'(ssel_low_b - s_low), DB * (2 * WB + 1));
    check({tag, " sck_rises"}, 32'(sck_rise_b - s_rise), WB);
    for (int n = 0; n < 20 && busy_b; n++) step();
  endtask

  initial begin
    int  s_low, s_rise, s_done, gap_run;
    bit  seen_low, hit;
    logic [31:0] w, r;

    // Reset state
    repeat (3) step();
    check("rst ssel", 32'(ssel_a), 32'd1);
    check("rst sck", 32'(sck_a), 32'd0);
    check("rst mosi", 32'(mosi_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst rx", rx_a, 32'd0);
    check("rst ssel_b", 32'(ssel_b), 32'd1);
    rst_n = 1'b1;
    step();

    // Directed loopback and slave frames
    frame_a("loop_cafebabe", 32'hCAFE_BABE, 1'b0, 32'd0);
    frame_a("slave_12345678", 32'h0000_00CC, 1'b1, 32'h1234_5678);

    // Randomized frames against the model
    for (int i = 0; i < 3; i++) begin
      w = $urandom();
      frame_a($sformatf("loop_rand%0d", i), w, 1'b0, 32'd0);
      w = $urandom();
      r = $urandom();
      frame_a($sformatf("slave_rand%0d", i), w, 1'b1, r);
    end

    // Reset after the 10th rising SCK edge
    use_slave = 1'b0;
    s_rise = sck_rise_a;
    s_done = done_cnt_a;
    tx_a    = $urandom();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      step();
      if (sck_rise_a - s_rise >= 10) hit = 1'b1;
    end
    check("midrst reached", 32'(hit), 32'd1);
    rst_n = 1'b0;
    step();
    check("midrst ssel", 32'(ssel_a), 32'd1);
    check("midrst sck", 32'(sck_a), 32'd0);
    check("midrst busy", 32'(busy_a), 32'd0);
    check("midrst mosi", 32'(mosi_a), 32'd0);
    check("midrst rx", rx_a, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (300) step();
    check("midrst no_done", 32'(done_cnt_a - s_done), 32'd0);
    frame_a("after_rst", $urandom(), 1'b0, 32'd0);

    // Start pulses inside a frame are ignored
    w = $urandom();
    s_low  = ssel_low_a;
    s_done = done_cnt_a;
    tx_a    = w;
    start_a = 1'b1;
    step();
    for (int c = 1; c <= 400; c++) begin
      start_a = (c == 5 || c == 50 || c == 200);
      step();
    end
    start_a = 1'b0;
    check("ignore done_count", 32'(done_cnt_a - s_done), 32'd1);
    check("ignore ssel_low", 32'(ssel_low_a - s_low), DA * (2 * WA + 1));
    check("ignore rx", rx_a, w);
    check("ignore busy", 32'(busy_a), 32'd0);

    // Start held: back-to-back frames with CS_GAP+1 idle-high cycles between
    w = $urandom();
    s_low  = ssel_low_a;
    s_done = done_cnt_a;
    tx_a    = w;
    start_a = 1'b1;
    gap_run  = 0;
    seen_low = 1'b0;
    for (int n = 0; n < 3000 && (done_cnt_a - s_done) < 3; n++) begin
      step();
      if (!ssel_a) begin
        if (seen_low && gap_run > 0) check("b2b gap", 32'(gap_run), GA + 1);
        gap_run  = 0;
        seen_low = 1'b1;
      end else if (seen_low) begin
        gap_run++;
      end
    end
    start_a = 1'b0;
    check("b2b done_count", 32'(done_cnt_a - s_done), 32'd3);
    check("b2b rx", rx_a, w);
    repeat (20) step();
    check("b2b ssel_low", 32'(ssel_low_a - s_low), 3 * DA * (2 * WA + 1));
    check("b2b idle", 32'(busy_a), 32'd0);

    // Small instance
    frame_b("b_a5", 8'hA5);
    for (int i = 0; i < 3; i++) frame_b($sformatf("b_rand%0d", i), 8'($urandom()));

    check("mosi_stable", 32'(mosi_bad_a), 32'd0);
    check("sck_outside_ssel_a", 32'(sck_bad_a), 32'd0);
    check("sck_outside_ssel_b", 32'(sck_bad_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
